// File: rtl/bsg_fsb_node_ls_iso_ctrl.sv
// FSB node-domain level-shift wrapper with an isolation sequencer that owns en_ls_o.
// Optional DRAIN timeout with sticky err_o: define BSG_FSB_NODE_LS_ISO_TIMEOUT_EN.
module bsg_fsb_node_ls_iso_ctrl #(
  parameter int width_p        = 80,
  parameter int drain_cycles_p = 4,
  parameter int wake_cycles_p  = 8,
  parameter int timeout_p      = 64
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               iso_req_i,
  output logic               iso_ack_o,
  output logic               en_ls_o,
  output logic               err_o,
  input  logic               node_v_o_i,
  input  logic [width_p-1:0] node_data_o_i,
  input  logic               fsb_yumi_o_i,
  output logic               fsb_v_i_o,
  output logic [width_p-1:0] fsb_data_i_o,
  output logic               node_yumi_i_o,
  input  logic               fsb_v_o_i,
  input  logic [width_p-1:0] fsb_data_o_i,
  input  logic               node_ready_o_i,
  output logic               node_v_i_o,
  output logic [width_p-1:0] node_data_i_o,
  output logic               fsb_ready_i_o
);

  localparam int max_dw_lp  = (drain_cycles_p > wake_cycles_p) ? drain_cycles_p : wake_cycles_p;
  localparam int max_lim_lp = (timeout_p > max_dw_lp) ? timeout_p : max_dw_lp;
  localparam int cnt_w_lp   = $clog2(max_lim_lp) + 1;

  localparam logic [cnt_w_lp-1:0] drain_lim_lp = cnt_w_lp'(drain_cycles_p);
  localparam logic [cnt_w_lp-1:0] wake_lim_lp  = cnt_w_lp'(wake_cycles_p);

  typedef enum logic [1:0] {
    s_active   = 2'd0,
    s_drain    = 2'd1,
    s_isolated = 2'd2,
    s_wake     = 2'd3
  } state_e;

  state_e              state_r, state_n;
  logic [cnt_w_lp-1:0] cnt_r, cnt_n, cnt_inc;

  assign cnt_inc = (&cnt_r) ? cnt_r : cnt_r + cnt_w_lp'(1);

`ifdef BSG_FSB_NODE_LS_ISO_TIMEOUT_EN
  localparam logic [cnt_w_lp-1:0] timeout_lim_lp = cnt_w_lp'(timeout_p);

  logic [cnt_w_lp-1:0] tmo_r, tmo_n, tmo_inc;
  logic                err_r, err_set;

  assign tmo_inc = (&tmo_r) ? tmo_r : tmo_r + cnt_w_lp'(1);
`endif

  // cnt_r counts consecutive idle cycles in DRAIN and elapsed cycles in WAKE.
  always_comb begin
    state_n = state_r;
    cnt_n   = '0;
`ifdef BSG_FSB_NODE_LS_ISO_TIMEOUT_EN
    tmo_n   = '0;
    err_set = 1'b0;
`endif
    case (state_r)
      s_active: begin
        if (iso_req_i) state_n = s_drain;
      end
      s_drain: begin
        if (!iso_req_i) begin
          state_n = s_active;
        end else begin
          cnt_n = node_v_o_i ? '0 : cnt_inc;
`ifdef BSG_FSB_NODE_LS_ISO_TIMEOUT_EN
          tmo_n = tmo_inc;
`endif
          if (cnt_n == drain_lim_lp) begin
            state_n = s_isolated;
          end
`ifdef BSG_FSB_NODE_LS_ISO_TIMEOUT_EN
          else if (tmo_n == timeout_lim_lp) begin
            state_n = s_isolated;
            err_set = 1'b1;
          end
`endif
        end
      end
      s_isolated: begin
        if (!iso_req_i) state_n = s_wake;
      end
      s_wake: begin
        if (iso_req_i) begin
          state_n = s_isolated;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_n == wake_lim_lp) state_n = s_active;
        end
      end
      default: state_n = s_isolated;
    endcase
    if (state_n != state_r) begin
      cnt_n = '0;
`ifdef BSG_FSB_NODE_LS_ISO_TIMEOUT_EN
      tmo_n = '0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= s_isolated;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

`ifdef BSG_FSB_NODE_LS_ISO_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tmo_r <= '0;
      err_r <= 1'b0;
    end else begin
      tmo_r <= tmo_n;
      if (err_set) err_r <= 1'b1;
    end
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

  logic pass_n2f, pass_f2n;

  assign en_ls_o   = (state_r != s_isolated);
  assign iso_ack_o = (state_r == s_isolated);
  assign pass_n2f  = (state_r == s_active) || (state_r == s_drain);
  assign pass_f2n  = (state_r == s_active);

  assign fsb_v_i_o     = node_v_o_i     & pass_n2f;
  assign node_yumi_i_o = fsb_yumi_o_i   & pass_n2f;
  assign node_v_i_o    = fsb_v_o_i      & pass_f2n;
  assign fsb_ready_i_o = node_ready_o_i & pass_f2n;

  assign fsb_data_i_o  = node_data_o_i & {width_p{en_ls_o}};
  assign node_data_i_o = fsb_data_o_i  & {width_p{en_ls_o}};

endmodule

// File: tb/tb_bsg_fsb_node_ls_iso_ctrl.sv
// Scoreboard bench for bsg_fsb_node_ls_iso_ctrl: per-cycle expected outputs from a
// behavioural model are queued by the stimulus and checked by an independent monitor.
module tb_bsg_fsb_node_ls_iso_ctrl;

  localparam int W = 8;
  localparam int D = 4;
  localparam int K = 8;
  localparam int T = 16;
`ifdef BSG_FSB_NODE_LS_ISO_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         iso_req_i;
  logic         iso_ack_o, en_ls_o, err_o;
  logic         node_v_o_i, fsb_yumi_o_i, fsb_v_o_i, node_ready_o_i;
  logic [W-1:0] node_data_o_i, fsb_data_o_i;
  logic         fsb_v_i_o, node_yumi_i_o, node_v_i_o, fsb_ready_i_o;
  logic [W-1:0] fsb_data_i_o, node_data_i_o;

  always #5 clk_i = ~clk_i;

  bsg_fsb_node_ls_iso_ctrl #(
    .width_p(W), .drain_cycles_p(D), .wake_cycles_p(K), .timeout_p(T)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .iso_req_i(iso_req_i),
    .iso_ack_o(iso_ack_o), .en_ls_o(en_ls_o), .err_o(err_o),
    .node_v_o_i(node_v_o_i), .node_data_o_i(node_data_o_i), .fsb_yumi_o_i(fsb_yumi_o_i),
    .fsb_v_i_o(fsb_v_i_o), .fsb_data_i_o(fsb_data_i_o), .node_yumi_i_o(node_yumi_i_o),
    .fsb_v_o_i(fsb_v_o_i), .fsb_data_o_i(fsb_data_o_i), .node_ready_o_i(node_ready_o_i),
    .node_v_i_o(node_v_i_o), .node_data_i_o(node_data_i_o), .fsb_ready_i_o(fsb_ready_i_o)
  );

  typedef struct packed {
    logic         ack, en, err, fv, nyumi, nv, frdy;
    logic [W-1:0] fdata, ndata;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  typedef enum {M_ACTIVE, M_DRAIN, M_ISOLATED, M_WAKE} mode_t;
  mode_t mode;
  int    idle_run, drain_time, wake_time;
  bit    m_err;

  function automatic void model_reset();
    mode = M_ISOLATED; idle_run = 0; drain_time = 0; wake_time = 0; m_err = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit en, n2f, f2n;
    en  = (mode != M_ISOLATED);
    n2f = (mode == M_ACTIVE) || (mode == M_DRAIN);
    f2n = (mode == M_ACTIVE);
    e.ack   = (mode == M_ISOLATED);
    e.en    = en;
    e.err   = m_err;
    e.fv    = n2f && node_v_o_i;
    e.nyumi = n2f && fsb_yumi_o_i;
    e.nv    = f2n && fsb_v_o_i;
    e.frdy  = f2n && node_ready_o_i;
    e.fdata = en ? node_data_o_i : '0;
    e.ndata = en ? fsb_data_o_i  : '0;
    return e;
  endfunction

  function automatic void model_edge();
    if (!reset_n_i) begin
      model_reset();
      return;
    end
    case (mode)
      M_ACTIVE: if (iso_req_i) begin mode = M_DRAIN; idle_run = 0; drain_time = 0; end
      M_DRAIN: begin
        if (!iso_req_i) mode = M_ACTIVE;
        else begin
          idle_run   = node_v_o_i ? 0 : idle_run + 1;
          drain_time = drain_time + 1;
          if (idle_run == D) mode = M_ISOLATED;
          else if (TMO_EN && drain_time == T) begin mode = M_ISOLATED; m_err = 1; end
        end
      end
      M_ISOLATED: if (!iso_req_i) begin mode = M_WAKE; wake_time = 0; end
      M_WAKE: begin
        if (iso_req_i) mode = M_ISOLATED;
        else begin
          wake_time = wake_time + 1;
          if (wake_time == K) mode = M_ACTIVE;
        end
      end
      default: mode = M_ISOLATED;
    endcase
  endfunction

  task automatic step();
    if (!reset_n_i) model_reset();
    q.push_back(model_out());
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic rand_hs(input int pct_v);
    node_v_o_i     = ($urandom_range(0, 99) < pct_v);
    fsb_yumi_o_i   = node_v_o_i & $urandom_range(0, 1);
    fsb_v_o_i      = $urandom_range(0, 1);
    node_ready_o_i = $urandom_range(0, 1);
    node_data_o_i  = W'($urandom);
    fsb_data_o_i   = W'($urandom);
  endtask

  task automatic run(input int n, input bit req, input int pct_v);
    for (int i = 0; i < n; i++) begin
      iso_req_i = req;
      rand_hs(pct_v);
      step();
    end
  endtask

  task automatic check_val(input string name, input logic [W-1:0] actual, input logic [W-1:0] required);
    checks++;
    if (actual === required) passes++;
    else $display("FAIL %s t=%0t actual=%h required=%h", name, $time, actual, required);
  endtask

  task automatic check_iso_state(input string tag);
    check_val({tag, "_iso_ack"}, W'(iso_ack_o), W'(1'b1));
    check_val({tag, "_en_ls"},   W'(en_ls_o),   W'(1'b0));
    check_val({tag, "_hs"},      W'({fsb_v_i_o, node_yumi_i_o, node_v_i_o, fsb_ready_i_o}), W'(4'b0000));
    check_val({tag, "_fdata"},   fsb_data_i_o,  W'(0));
  endtask

  exp_t act, exp_v;
  always @(negedge clk_i) begin
    if (q.size() != 0) begin
      exp_v = q.pop_front();
      act = {iso_ack_o, en_ls_o, err_o, fsb_v_i_o, node_yumi_i_o, node_v_i_o, fsb_ready_i_o,
             fsb_data_i_o, node_data_i_o};
      checks++;
      if (act === exp_v) passes++;
      else $display("FAIL cycle_outputs t=%0t actual=%b required=%b (ack,en,err,fv,nyumi,nv,frdy,fdata,ndata)",
                    $time, act, exp_v);
    end
  end

  initial begin
    model_reset();
    reset_n_i = 1'b0; iso_req_i = 1'b0;
    node_v_o_i = 0; fsb_yumi_o_i = 0; fsb_v_o_i = 0; node_ready_o_i = 0;
    node_data_o_i = '0; fsb_data_o_i = '0;
    @(posedge clk_i); #1;
    check_iso_state("reset_state");
    check_val("reset_err", W'(err_o), W'(1'b0));
    run(3, 1'b0, 50);
    reset_n_i = 1'b1;
    run(10, 1'b0, 50);
    for (int i = 0; i < 4; i++) begin
      iso_req_i = 0; rand_hs(50); node_data_o_i = 8'hA5; step();
    end
    // idle drain to isolation, then wake back
    run(6, 1'b1, 0);
    check_iso_state("drain_expired");
    run(12, 1'b0, 50);
    // busy drain: valid three cycles with yumi on the third, then idle
    for (int i = 0; i < 3; i++) begin
      iso_req_i = 1; rand_hs(100); fsb_yumi_o_i = (i == 2); step();
    end
    run(6, 1'b1, 0);
    run(10, 1'b0, 50);
    // aborted drain must clear the idle run
    run(2, 1'b1, 0);
    run(1, 1'b0, 0);
    run(5, 1'b1, 0);
    run(12, 1'b0, 50);
    // held-valid drain: timeout path or indefinite wait
    run(100, 1'b1, 100);
    run(12, 1'b0, 50);
    // reset pulse mid-WAKE
    run(5, 1'b1, 0);
    run(3, 1'b0, 50);
    reset_n_i = 0; run(1, 1'b0, 50); reset_n_i = 1;
    run(12, 1'b0, 50);
    // reset pulse mid-DRAIN
    run(2, 1'b1, 100);
    reset_n_i = 0; #1;
    check_iso_state("async_reset_drain");
    check_val("async_reset_err", W'(err_o), W'(1'b0));
    run(1, 1'b1, 100); reset_n_i = 1;
    run(3, 1'b1, 50);
    run(12, 1'b0, 50);
    // random soak
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 6) iso_req_i = ~iso_req_i;
      rand_hs(30);
      if ($urandom_range(0, 199) == 0) begin
        reset_n_i = 0; step(); reset_n_i = 1;
      end else begin
        step();
      end
    end
    @(negedge clk_i); #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bsg_fsb_node_ls_iso_ctrl.md
# bsg_fsb_node_ls_iso_ctrl

Parametrised successor to the fixed-width FSB node-domain level-shift wrapper. It owns the level-shift enable instead of taking it as an input. A four-state isolation FSM quiesces both FSB handshake directions before the node domain is isolated, and holds handshakes masked while the shifters settle on wake-up. It sits between an FSB node and the FSB, in the node's always-on domain.

## Interface
Parameters:
- width_p, 80: data width of both directions.
- drain_cycles_p, 4: consecutive idle cycles required on node→FSB valid before isolation (≥1).
- wake_cycles_p, 8: cycles handshakes stay masked after enable reassertion (≥1).
- timeout_p, 64: DRAIN cycle limit, used only with the timeout macro (> drain_cycles_p).

Ports. Clock and reset: one clock, `clk_i`; reset is asynchronous and active-low, `reset_n_i`.
- clk_i  in  1  clock
- reset_n_i  in  1  async active-low reset
- iso_req_i  in  1  level request to isolate the node
- iso_ack_o  out  1  node isolated; safe to power down
- en_ls_o  out  1  level-shifter enable
- err_o  out  1  sticky: isolation forced by timeout
- node_v_o_i  in  1  node→FSB valid
- node_data_o_i  in  width_p  node→FSB data
- fsb_yumi_o_i  in  1  FSB consumes node→FSB word
- fsb_v_i_o  out  1  valid to FSB
- fsb_data_i_o  out  width_p  data to FSB
- node_yumi_i_o  out  1  yumi to node
- fsb_v_o_i  in  1  FSB→node valid
- fsb_data_o_i  in  width_p  FSB→node data
- node_ready_o_i  in  1  node ready for FSB→node
- node_v_i_o  out  1  valid to node
- node_data_i_o  out  width_p  data to node
- fsb_ready_i_o  out  1  ready to FSB

## Operation
- States: ACTIVE, DRAIN, ISOLATED, WAKE. The reset state is ISOLATED.
- Data outputs equal the corresponding data input ANDed bitwise with en_ls_o, in every state.
- ACTIVE: all handshakes pass through.
  - fsb_v_i_o=node_v_o_i; node_yumi_i_o=fsb_yumi_o_i; node_v_i_o=fsb_v_o_i; fsb_ready_i_o=node_ready_o_i.
  - iso_req_i=1 → DRAIN.
- DRAIN: FSB→node is blocked.
  - node_v_i_o=0 and fsb_ready_i_o=0, so no new FSB→node transfer can occur.
  - Node→FSB still passes through, letting an outstanding word be yumi'd.
  - The idle counter increments when node_v_o_i=0 and clears to 0 when node_v_o_i=1.
  - Idle count == drain_cycles_p → ISOLATED.
  - iso_req_i=0 → ACTIVE. This takes priority over the idle condition.
- ISOLATED: everything is forced off.
  - en_ls_o=0 and iso_ack_o=1; all four handshake outputs are 0.
  - iso_req_i=0 → WAKE.
- WAKE: shifters enabled, handshakes still masked.
  - en_ls_o=1, iso_ack_o=0; all four handshake outputs are 0.
  - The counter counts up to wake_cycles_p, then → ACTIVE.
  - iso_req_i=1 → ISOLATED immediately. No transfer is possible in WAKE, so no drain is needed.
- Counters: width $clog2 of the largest limit + 1. They clear on every state entry and saturate; they never wrap.
- Asserting reset_n_i low in any state immediately gives ISOLATED, counters 0 and err_o=0, and all handshake outputs 0.

## Timing
- The state register updates on the clk_i rising edge. Outputs decode combinationally from state.
- iso_req_i is sampled at the edge: a request seen at edge N gives masked outputs from edge N onward.
- Data and handshake pass-through is combinational, with zero latency.
- Minimum request-to-iso_ack_o latency is drain_cycles_p cycles, reached with node_v_o_i held low.
- iso_ack_o falls the cycle after iso_req_i=0 is sampled. The first ACTIVE cycle follows wake_cycles_p cycles later.
- Reset output values: iso_ack_o=1, en_ls_o=0, err_o=0; all valid/ready/yumi and data outputs 0.

## Configuration
- BSG_FSB_NODE_LS_ISO_TIMEOUT_EN defined:
  - A DRAIN cycle counter runs; on reaching timeout_p the block goes to ISOLATED and sets err_o.
  - err_o stays set until reset.
  - Timeout and idle completion in the same cycle → ISOLATED with err_o=0.
- Not defined: DRAIN waits indefinitely, and err_o is tied 0.

## Test plan
All scenarios use width_p=8, drain_cycles_p=4, wake_cycles_p=8, timeout_p=16.
- Reset release with iso_req_i=0 → iso_ack_o=1 for 1 cycle, then 8 WAKE cycles with handshakes 0 and en_ls_o=1, then pass-through (node_data_o_i=8'hA5 → fsb_data_i_o=8'hA5).
- ACTIVE, iso_req_i=1, node_v_o_i=0 → node_v_i_o/fsb_ready_i_o=0 from the next cycle; iso_ack_o=1 exactly 4 cycles later; fsb_data_i_o=8'h00.
- DRAIN with node_v_o_i=1 for 3 cycles, yumi on the 3rd → yumi passes to node_yumi_i_o; iso_ack_o asserts 4 cycles after node_v_o_i falls.
- DRAIN after 2 idle cycles, iso_req_i=0 → ACTIVE next cycle, no isolation, counters cleared.
- Macro defined, node_v_o_i held 1 in DRAIN → ISOLATED and err_o=1 after 16 cycles; err_o stays 1 through wake; without the macro, still DRAIN at 100 cycles.
- reset_n_i pulsed low mid-WAKE and mid-DRAIN → asynchronously ISOLATED, all handshakes 0, err_o=0.
